control_puertas: RTL and testbench

CONTROL_PUERTAS -- requirements
Module: control_puertas

---
 rtl/control_puertas_if.sv | 19 +
 rtl/control_puertas.sv | 77 +++++++
 tb/tb_control_puertas.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/control_puertas_if.sv
// control_puertas_if: algorithm/cabin-side signals of the door controller.
interface control_puertas_if;
  logic [1:0] motor;
  logic       abrir;
  logic       boton_abrir;
  logic       obstaculo;
  logic       esperar;
  logic [1:0] actuador;
  logic       puerta_cerrada;
  logic       falla;
  modport master (
    output motor, abrir, boton_abrir, obstaculo,
    input  esperar, actuador, puerta_cerrada, falla
  );
  modport slave (
    input  motor, abrir, boton_abrir, obstaculo,
    output esperar, actuador, puerta_cerrada, falla
  );
endinterface

// File: rtl/control_puertas.sv
// control_puertas: elevator door sequencer with travel/dwell timing, reopen and sticky motor fault.
// Define OBSTACLE_REOPEN_EN to let the edge sensor reverse a closing door.
module control_puertas #(
  parameter int T_MOVE = 4,
  parameter int T_OPEN = 8
) (
  input logic clk,
  input logic rst_n,
  control_puertas_if.slave bus
);
  typedef enum logic [1:0] {CERRADA, ABRIENDO, ABIERTA, CERRANDO} state_t;
  localparam logic [15:0] move_c = 16'(T_MOVE);
  localparam logic [15:0] open_c = 16'(T_OPEN);
  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx, recorrido;
  logic        pedido, reabrir, expira, parado;
  logic        esperar, puerta_cerrada, falla;
  logic [1:0]  actuador;
  assign parado = bus.motor == 2'b00;
  assign pedido = bus.abrir | bus.boton_abrir;
`ifdef OBSTACLE_REOPEN_EN
  assign reabrir = pedido | bus.obstaculo;
`else
  assign reabrir = pedido;
`endif
  assign expira = cnt <= 16'd1;
  // reopening takes as long as the door has already closed, never less than one cycle
  assign recorrido = (move_c == cnt) ? 16'd1 : move_c - cnt;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CERRADA: if (pedido && parado) begin
        state_nx = ABRIENDO;
        cnt_nx   = move_c;
      end
      ABRIENDO: begin
        state_nx = expira ? ABIERTA : ABRIENDO;
        cnt_nx   = expira ? open_c : cnt - 16'd1;
      end
      ABIERTA: if (pedido || bus.obstaculo) cnt_nx = open_c;
      else begin
        state_nx = expira ? CERRANDO : ABIERTA;
        cnt_nx   = expira ? move_c : cnt - 16'd1;
      end
      CERRANDO: if (reabrir) begin
        state_nx = ABRIENDO;
        cnt_nx   = recorrido;
      end else begin
        state_nx = expira ? CERRADA : CERRANDO;
        cnt_nx   = expira ? 16'd0 : cnt - 16'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= CERRADA;
      cnt            <= '0;
      esperar        <= 1'b0;
      actuador       <= 2'b00;
      puerta_cerrada <= 1'b1;
      falla          <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      esperar        <= state_nx != CERRADA;
      actuador       <= state_nx == ABRIENDO ? 2'b01 : state_nx == CERRANDO ? 2'b10 : 2'b00;
      puerta_cerrada <= state_nx == CERRADA;
      falla          <= falla | (state != CERRADA && !parado);
    end
  end
  assign bus.esperar        = esperar;
  assign bus.actuador       = actuador;
  assign bus.puerta_cerrada = puerta_cerrada;
  assign bus.falla          = falla;
endmodule

// File: tb/tb_control_puertas.sv
// tb_control_puertas: vector table, directed corner sequences and random run against a deadline-based door model.
module tb_control_puertas;
  localparam int T_MOVE = 4;
  localparam int T_OPEN = 8;
`ifdef OBSTACLE_REOPEN_EN
  localparam bit reopen_obs = 1'b1;
`else
  localparam bit reopen_obs = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  control_puertas_if bus ();
  control_puertas #(.T_MOVE(T_MOVE), .T_OPEN(T_OPEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef enum {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING} mode_t;
  typedef struct {
    logic       rn;
    logic [1:0] m;
    logic       a, b, o;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[21];
  mode_t mode = M_CLOSED;
  int n = 0;
  int d = 0;
  logic fm = 1'b0;
  function automatic vec_t mk(logic rn, logic [1:0] m, logic a, logic b, logic o, logic [4:0] e);
    vec_t v;
    v.rn = rn; v.m = m; v.a = a; v.b = b; v.o = o; v.exp = e;
    return v;
  endfunction
  function automatic logic [4:0] got();
    return {bus.esperar, bus.actuador, bus.puerta_cerrada, bus.falla};
  endfunction
  function automatic logic [4:0] expv();
    logic [1:0] act;
    act = mode == M_OPENING ? 2'b01 : mode == M_CLOSING ? 2'b10 : 2'b00;
    return {mode != M_CLOSED, act, mode == M_CLOSED, fm};
  endfunction
  task automatic check(input string name, input logic [4:0] g, input logic [4:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (esperar,actuador,puerta_cerrada,falla) t=%0t", name, g, e, $time);
    end
  endtask
  task automatic check_int(input string name, input int g, input int e);
    checks++;
    if (g != e) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, g, e, $time);
    end
  endtask
  // the model tracks the absolute edge at which the current phase ends
  task automatic model(input logic rn, input logic [1:0] m, input logic a, input logic b, input logic o);
    int rest, dur;
    n++;
    if (!rn) begin
      mode = M_CLOSED;
      fm = 1'b0;
      return;
    end
    if (mode != M_CLOSED && m != 2'b00) fm = 1'b1;
    case (mode)
      M_CLOSED: if ((a || b) && m == 2'b00) begin mode = M_OPENING; d = n + T_MOVE; end
      M_OPENING: if (n == d) begin mode = M_OPEN; d = n + T_OPEN; end
      M_OPEN: if (a || b || o) d = n + T_OPEN;
              else if (n == d) begin mode = M_CLOSING; d = n + T_MOVE; end
      M_CLOSING: begin
        rest = d - n + 1;
        dur = T_MOVE - rest;
        if (a || b || (reopen_obs && o)) begin
          mode = M_OPENING;
          d = n + (dur < 1 ? 1 : dur);
        end else if (n == d) mode = M_CLOSED;
      end
      default: ;
    endcase
  endtask
  task automatic step(input logic rn, input logic [1:0] m, input logic a, input logic b, input logic o);
    rst_n = rn;
    bus.motor = m;
    bus.abrir = a;
    bus.boton_abrir = b;
    bus.obstaculo = o;
    @(posedge clk);
    #1;
    model(rn, m, a, b, o);
    check("model", got(), expv());
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    int found, run;
    tbl[0] = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00010);
    tbl[1] = mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'b10100);
    for (int i = 2; i <= 4; i++) tbl[i] = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b10100);
    for (int i = 5; i <= 12; i++) tbl[i] = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b10000);
    for (int i = 13; i <= 16; i++) tbl[i] = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b11000);
    tbl[17] = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00010);
    tbl[18] = mk(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 5'b00010);
    tbl[19] = mk(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 5'b00010);
    tbl[20] = mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 5'b00010);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rn, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].o);
      check($sformatf("table[%0d]", i), got(), tbl[i].exp);
    end
    // dwell held open by the button, then closing starts a full dwell after release
    step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("open_reached", got(), 5'b10000);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
      check("dwell_hold", got(), 5'b10000);
    end
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      idle(1);
      if (bus.actuador == 2'b10) found = i;
    end
    check_int("close_after_release", found, 8);
    // reopen after three closing cycles lasts three cycles
    idle(3);
    step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    run = bus.actuador == 2'b01 ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (bus.actuador != 2'b01) break;
      run++;
    end
    check_int("reopen_len", run, 3);
    check("reopen_then_open", got(), 5'b10000);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    check("falla_set", got(), 5'b10001);
    idle(3);
    check("falla_held", {4'b0, bus.falla}, 5'b00001);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("reset_values", got(), 5'b00010);
    step(1'b0, 2'b11, 1'b1, 1'b1, 1'b1);
    check("reset_dominates", got(), 5'b00010);
    step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    check("first_req", got(), 5'b10100);
    idle(4 + 8);
    check("closing_reached", got(), 5'b11000);
    idle(2);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
`ifdef OBSTACLE_REOPEN_EN
    check("obst_reverse", got(), 5'b10100);
    idle(1);
    check("obst_reverse2", got(), 5'b10100);
    idle(1);
    check("obst_open", got(), 5'b10000);
`else
    check("obst_ignored", got(), 5'b11000);
    idle(1);
    check("obst_closed", got(), 5'b00010);
`endif
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2500; i++) begin
      logic [1:0] m;
      m = $urandom_range(0, 29) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      step($urandom_range(0, 199) != 0, m, $urandom_range(0, 11) == 0,
           $urandom_range(0, 14) == 0, $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
